// File: rtl/stopwatch_core.sv
// Stopwatch engine: RUN/STOP/CLEAR control, tick prescaler, DIGITS-wide BCD
// up/down counter with wrap pulse, and a lap snapshot that freezes the display.
module stopwatch_core #(
    parameter int CLK_HZ  = 100_000_000,
    parameter int TICK_HZ = 100,
    parameter int DIGITS  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_run_stop,
    input  logic                  i_clear,
    input  logic                  i_lap,
    input  logic                  i_down,
    output logic [4*DIGITS-1:0]   o_bcd,
    output logic                  o_running,
    output logic                  o_lap,
    output logic                  o_tick,
    output logic                  o_wrap
);

    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW  = (DIV > 2) ? $clog2(DIV) : 1;
    localparam int BW  = 4 * DIGITS;
    localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);
    localparam logic [BW-1:0] ALL_NINES = {DIGITS{4'h9}};

    if (DIV < 2) begin : g_bad_div
        $fatal(1, "stopwatch_core: CLK_HZ/TICK_HZ must be at least 2");
    end
    if (DIGITS < 1 || DIGITS > 8) begin : g_bad_digits
        $fatal(1, "stopwatch_core: DIGITS must be in 1..8");
    end

    typedef enum logic [1:0] {
        ST_STOP  = 2'd0,
        ST_RUN   = 2'd1,
        ST_CLEAR = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic [BW-1:0]   count_q, count_d;
    logic [BW-1:0]   snap_q,  snap_d;
    logic            lap_q,   lap_d;
    logic            tick;

    // Ripple carry/borrow through the digits; each digit only ever steps
    // between 0 and 9, so the full-wrap case falls out naturally.
    function automatic logic [BW-1:0] bcd_step(input logic [BW-1:0] v, input logic down);
        logic [BW-1:0] r;
        logic          carry;
        logic [3:0]    d;
        r     = v;
        carry = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            d = v[4*k +: 4];
            if (carry) begin
                if (down) begin
                    if (d == 4'd0) begin
                        d = 4'd9;
                    end else begin
                        d     = d - 4'd1;
                        carry = 1'b0;
                    end
                end else begin
                    if (d == 4'd9) begin
                        d = 4'd0;
                    end else begin
                        d     = d + 4'd1;
                        carry = 1'b0;
                    end
                end
                r[4*k +: 4] = d;
            end
        end
        return r;
    endfunction

    assign tick   = (state_q == ST_RUN) && (presc_q == PRESC_MAX);
    assign o_tick = tick;
    assign o_wrap = tick && (i_down ? (count_q == '0) : (count_q == ALL_NINES));

    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        count_d = count_q;
        snap_d  = snap_q;
        lap_d   = lap_q;
        case (state_q)
            ST_STOP: begin
                if (i_lap) begin
                    lap_d = 1'b0;
                end
                if (i_run_stop) begin
                    state_d = ST_RUN;
                end else if (i_clear) begin
                    state_d = ST_CLEAR;
                    lap_d   = 1'b0;
                end
            end
            ST_RUN: begin
                if (i_run_stop) begin
                    state_d = ST_STOP;
                end
                presc_d = tick ? '0 : presc_q + PW'(1);
                if (tick) begin
                    count_d = bcd_step(count_q, i_down);
                end
                // Snapshot takes the pre-step count even on a tick cycle
                if (i_lap) begin
                    if (lap_q) begin
                        lap_d = 1'b0;
                    end else begin
                        snap_d = count_q;
                        lap_d  = 1'b1;
                    end
                end
            end
            ST_CLEAR: begin
                state_d = ST_STOP;
                presc_d = '0;
                count_d = '0;
            end
            default: begin
                state_d = ST_STOP;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_STOP;
            presc_q <= '0;
            count_q <= '0;
            snap_q  <= '0;
            lap_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            count_q <= count_d;
            snap_q  <= snap_d;
            lap_q   <= lap_d;
        end
    end

    assign o_running = (state_q == ST_RUN);
    assign o_lap     = lap_q;
    assign o_bcd     = lap_q ? snap_q : count_q;

endmodule

// File: tb/tb_stopwatch_core.sv
// Directed bench for stopwatch_core: expected display/wrap values are queued
// as stimulus is applied and compared when each o_tick appears.
module tb_stopwatch_core;

    typedef struct packed {
        logic [15:0] bcd;
        logic        wrap;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rs = 1'b0, cl = 1'b0, lp = 1'b0, dn = 1'b0;
    logic        rs2 = 1'b0, cl2 = 1'b0, lp2 = 1'b0, dn2 = 1'b0;
    logic [15:0] o_bcd;
    logic [7:0]  o_bcd2;
    logic        o_running, o_lap, o_tick, o_wrap;
    logic        o_running2, o_lap2, o_tick2, o_wrap2;
    logic        sel2 = 1'b0;
    logic        mon_tick, mon_wrap;
    logic [15:0] mon_bcd;

    int   vectors = 0;
    int   errors  = 0;
    exp_t q[$];

    always #5 clk = ~clk;

    stopwatch_core #(.CLK_HZ(1000), .TICK_HZ(100), .DIGITS(4)) u_dut (
        .clk(clk), .reset(reset),
        .i_run_stop(rs), .i_clear(cl), .i_lap(lp), .i_down(dn),
        .o_bcd(o_bcd), .o_running(o_running), .o_lap(o_lap),
        .o_tick(o_tick), .o_wrap(o_wrap)
    );

    stopwatch_core #(.CLK_HZ(1000), .TICK_HZ(100), .DIGITS(2)) u_dut2 (
        .clk(clk), .reset(reset),
        .i_run_stop(rs2), .i_clear(cl2), .i_lap(lp2), .i_down(dn2),
        .o_bcd(o_bcd2), .o_running(o_running2), .o_lap(o_lap2),
        .o_tick(o_tick2), .o_wrap(o_wrap2)
    );

    assign mon_tick = sel2 ? o_tick2 : o_tick;
    assign mon_wrap = sel2 ? o_wrap2 : o_wrap;
    assign mon_bcd  = sel2 ? {8'h00, o_bcd2} : o_bcd;

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        int          t;
        r = '0;
        t = v;
        for (int k = 0; k < 4; k++) begin
            r[4*k +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [15:0] b, input logic w);
        exp_t e;
        e.bcd  = b;
        e.wrap = w;
        q.push_back(e);
    endtask

    task automatic pulse(input logic p_rs, input logic p_cl, input logic p_lp);
        rs = p_rs;
        cl = p_cl;
        lp = p_lp;
        @(negedge clk);
        rs = 1'b0;
        cl = 1'b0;
        lp = 1'b0;
    endtask

    // Waits (bounded) for the next tick, then checks latency, wrap and the
    // display value one cycle later against the head of the queue.
    task automatic do_tick(input int exp_lat);
        int   n;
        exp_t e;
        n = 0;
        while (mon_tick !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("tick_seen", {31'b0, mon_tick}, 32'd1);
        chk("tick_latency", n, exp_lat);
        chk("sb_nonempty", {31'b0, q.size() != 0}, 32'd1);
        if (q.size() != 0) begin
            e = q.pop_front();
        end else begin
            e.bcd  = 16'hffff;
            e.wrap = 1'b0;
        end
        chk("wrap", {31'b0, mon_wrap}, {31'b0, e.wrap});
        @(negedge clk);
        chk("bcd", {16'b0, mon_bcd}, {16'b0, e.bcd});
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_bcd", o_bcd, 0);
        chk("rst_run", o_running, 0);
        chk("rst_lap", o_lap, 0);
        chk("rst_tick", o_tick, 0);
        chk("rst_wrap", o_wrap, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("idle_bcd", o_bcd, 0);

        // First run: latency and 25 ticks
        pulse(1, 0, 0);
        chk("run_on", o_running, 1);
        for (int i = 1; i <= 25; i++) push(to_bcd(i), 1'b0);
        do_tick(9);
        for (int i = 2; i <= 25; i++) do_tick(9);

        // Stop with prescaler at 7, idle, resume
        repeat (6) @(negedge clk);
        pulse(1, 0, 0);
        chk("stopped", o_running, 0);
        repeat (50) @(negedge clk);
        chk("hold_bcd", o_bcd, 16'h0025);
        pulse(1, 0, 0);
        push(16'h0026, 1'b0);
        do_tick(2);

        // Clear ignored in RUN
        pulse(0, 1, 0);
        chk("clr_in_run", o_running, 1);
        chk("clr_in_run_bcd", o_bcd, 16'h0026);
        push(16'h0027, 1'b0);
        do_tick(8);

        // Run and clear together in STOP: run wins
        pulse(1, 0, 0);
        chk("stop2", o_running, 0);
        pulse(1, 1, 0);
        chk("both_run", o_running, 1);
        chk("both_bcd", o_bcd, 16'h0027);
        push(16'h0028, 1'b0);
        do_tick(8);

        // Clear in STOP: zero two cycles after the pulse
        pulse(1, 0, 0);
        pulse(0, 1, 0);
        chk("clr_n1_bcd", o_bcd, 16'h0028);
        chk("clr_n1_run", o_running, 0);
        @(negedge clk);
        chk("clr_n2_bcd", o_bcd, 16'h0000);
        chk("clr_n2_run", o_running, 0);

        // Down wrap then up wrap through 9999
        dn = 1'b1;
        push(16'h9999, 1'b1);
        push(16'h9998, 1'b0);
        pulse(1, 0, 0);
        do_tick(9);
        do_tick(9);
        dn = 1'b0;
        push(16'h9999, 1'b0);
        push(16'h0000, 1'b1);
        do_tick(9);
        do_tick(9);

        // Lap hold at 42 across 30 ticks
        for (int i = 1; i <= 42; i++) push(to_bcd(i), 1'b0);
        for (int i = 1; i <= 42; i++) do_tick(9);
        pulse(0, 0, 1);
        chk("lap_set", o_lap, 1);
        chk("lap_bcd", o_bcd, 16'h0042);
        for (int i = 0; i < 30; i++) push(16'h0042, 1'b0);
        do_tick(8);
        for (int i = 1; i < 30; i++) do_tick(9);
        pulse(0, 0, 1);
        chk("lap_rel", o_lap, 0);
        chk("lap_rel_bcd", o_bcd, 16'h0072);

        // Lap on a tick cycle captures the pre-step value
        push(16'h0073, 1'b0);
        do_tick(8);
        repeat (9) @(negedge clk);
        chk("tick_cycle", o_tick, 1);
        pulse(0, 0, 1);
        chk("lap_tick_set", o_lap, 1);
        chk("lap_tick_bcd", o_bcd, 16'h0073);
        pulse(1, 0, 0);
        chk("lap_stop_keep", o_lap, 1);
        pulse(0, 0, 1);
        chk("lap_stop_clr", o_lap, 0);
        chk("lap_stop_bcd", o_bcd, 16'h0074);
        pulse(0, 1, 0);
        @(negedge clk);
        chk("clr2_bcd", o_bcd, 16'h0000);

        // Async reset mid-run at prescaler 5, count 13
        for (int i = 1; i <= 13; i++) push(to_bcd(i), 1'b0);
        pulse(1, 0, 0);
        for (int i = 1; i <= 13; i++) do_tick(9);
        repeat (5) @(negedge clk);
        chk("pre_rst_bcd", o_bcd, 16'h0013);
        reset = 1'b1;
        #1;
        chk("arst_bcd", o_bcd, 0);
        chk("arst_run", o_running, 0);
        chk("arst_lap", o_lap, 0);
        chk("arst_tick", o_tick, 0);
        chk("arst_wrap", o_wrap, 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_run", o_running, 0);
        push(16'h0001, 1'b0);
        pulse(1, 0, 0);
        do_tick(9);

        // Two-digit instance: 00 -> 99 down wrap, 99 -> 00 up wrap
        sel2 = 1'b1;
        dn2  = 1'b1;
        push(16'h0099, 1'b1);
        push(16'h0098, 1'b0);
        rs2 = 1'b1;
        @(negedge clk);
        rs2 = 1'b0;
        chk("d2_run", o_running2, 1);
        do_tick(9);
        do_tick(9);
        dn2 = 1'b0;
        push(16'h0099, 1'b0);
        push(16'h0000, 1'b1);
        do_tick(9);
        do_tick(9);

        chk("sb_drained", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
